// File: rtl/pxor_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pxor_frame_sched_pkg
// Purpose  : Shared state encodings and lane count for the frame XOR
//            scheduler and its quad stage.
// Contents : state_t    - scheduler FSM states (IDLE/LOAD/DRAIN/HOLD)
//            PXOR_LANES - number of words packed into one quad
// Revision : 1.0 - initial release
// ============================================================================
package pxor_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int PXOR_LANES = 4;

endpackage
`default_nettype wire

// File: rtl/pxor_quad_stage.sv
`default_nettype none
// ============================================================================
// Module   : pxor_quad_stage
// Purpose  : Registered 4:1 XOR of one packed quad, with a valid flag.
// Ports    : clk, rst (async, active-high), clk_ena (register enable)
//            quad_in [4*WIDTH] - four lanes, lane 0 in the LSBs
//            vld_in            - quad_in holds a quad this cycle
//            sum     [WIDTH]   - registered XOR of the four lanes
//            vld               - sum is valid
// Revision : 1.0 - initial release
// ============================================================================
module pxor_quad_stage
  import pxor_frame_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_ena,
  input  logic [PXOR_LANES*WIDTH-1:0] quad_in,
  input  logic                        vld_in,
  output logic [WIDTH-1:0]            sum,
  output logic                        vld
);

  logic [WIDTH-1:0] w_xor;

  always_comb begin
    w_xor = '0;
    for (int l = 0; l < PXOR_LANES; l++) begin
      w_xor = w_xor ^ quad_in[l*WIDTH +: WIDTH];
    end
  end

  // Sum is forced to zero when no quad is present so nothing stale leaks
  // into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      vld <= 1'b0;
    end else if (clk_ena) begin
      sum <= vld_in ? w_xor : '0;
      vld <= vld_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pxor_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : pxor_frame_sched
// Purpose  : Frame scheduler for the pipelined mod-2 summation datapath.
//            Packs frame words into quads, XORs each quad in a shared
//            registered stage and accumulates the frame sum.
// Ports    : clk, rst (async, active-high), clk_ena (global enable)
//            start, frame_len [LEN_W] - begin a frame (IDLE only)
//            busy                     - state != IDLE
//            din [WIDTH], din_valid, din_ready - word handshake
//            sum_out [WIDTH], sum_valid, sum_ack - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module pxor_frame_sched
  import pxor_frame_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_ena,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ack
);

  state_t                        r_state;
  logic [LEN_W-1:0]              r_len;
  logic [LEN_W-1:0]              r_cnt;
  logic [PXOR_LANES*WIDTH-1:0]   r_slots;
  logic [PXOR_LANES*WIDTH-1:0]   r_quad;
  logic                          r_quad_vld;
  logic [WIDTH-1:0]              r_acc;
  logic [WIDTH-1:0]              w_stage_sum;
  logic                          w_stage_vld;
  logic [PXOR_LANES*WIDTH-1:0]   w_packed;
  logic [1:0]                    w_lane;
  logic                          w_xfer;
  logic                          w_last;
  logic                          w_begin;

  // din_ready is a registered decode of LOAD, so it never depends on din_valid.
  assign w_xfer  = din_valid & din_ready;
  assign w_last  = (r_cnt == r_len - 1'b1);
  assign w_lane  = r_cnt[1:0];
  assign w_begin = (r_state == ST_IDLE) & start;

  // Partial quad with the incoming word dropped into its lane.
  always_comb begin
    w_packed = r_slots;
    for (int l = 0; l < PXOR_LANES; l++) begin
      if (w_lane == l[1:0]) begin
        w_packed[l*WIDTH +: WIDTH] = din;
      end
    end
  end

  // Lane packer and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slots    <= '0;
      r_quad     <= '0;
      r_quad_vld <= 1'b0;
      r_acc      <= '0;
    end else if (clk_ena) begin
      if (w_begin) begin
        r_slots    <= '0;
        r_quad_vld <= 1'b0;
        r_acc      <= '0;
      end else begin
        r_quad_vld <= 1'b0;
        if (w_xfer) begin
          // A full quad or the tail of the frame is issued; unused lanes
          // remain zero because the slots are cleared on every issue.
          if (w_lane == 2'd3 || w_last) begin
            r_quad     <= w_packed;
            r_quad_vld <= 1'b1;
            r_slots    <= '0;
          end else begin
            r_slots <= w_packed;
          end
        end
        if (w_stage_vld) begin
          r_acc <= r_acc ^ w_stage_sum;
        end
      end
    end
  end

  pxor_quad_stage #(
    .WIDTH (WIDTH)
  ) u_quad_stage (
    .clk     (clk),
    .rst     (rst),
    .clk_ena (clk_ena),
    .quad_in (r_quad),
    .vld_in  (r_quad_vld),
    .sum     (w_stage_sum),
    .vld     (w_stage_vld)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      din_ready <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else if (clk_ena) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (frame_len != '0) begin
              r_len     <= frame_len;
              r_cnt     <= '0;
              din_ready <= 1'b1;
              r_state   <= ST_LOAD;
            end else begin
              sum_valid <= 1'b1;
              sum_out   <= '0;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              din_ready <= 1'b0;
              r_state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Both pipeline stages empty means r_acc already holds the sum.
          if (!r_quad_vld && !w_stage_vld) begin
            sum_valid <= 1'b1;
            sum_out   <= r_acc;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (sum_ack) begin
            busy      <= 1'b0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
